// File: rtl/manta_bus_pkg.sv
// Shared bus definitions for the manta IO core and its bridges.
// Bus widths and the transaction bundle carried between blocks.
package manta_bus_pkg;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int BUS_DATA_WIDTH = 16;

    typedef struct packed {
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0] data;
        logic                      rw;
        logic                      valid;
    } bus_txn_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bus_resp_fifo.sv
// Read-response FIFO between the IO core bus output and bridge_tx.
// Write echoes are filtered; drops on a full FIFO are flagged and counted.
module bus_resp_fifo
    import manta_bus_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic                       rw_i,
    input  logic                       valid_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;

    logic push, pop, full, accept, drop;

    assign push   = valid_i && !rw_i;
    assign pop    = valid_o && ready_i;
    assign full   = (count_q == FULL_CNT);
    // A full FIFO still takes a push when the head leaves the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = sat_inc16(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o       = mem_q[rd_ptr_q];
    assign valid_o      = (count_q != '0);
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule
